gray_code_counter: RTL and testbench

GRAY_CODE_COUNTER -- requirements
Module: gray_code_counter

---
 rtl/gray_code_counter_pkg.sv | 19 +
 rtl/gray_code_counter_if.sv | 24 ++
 rtl/gray_code_counter_encoder.sv | 11 +
 rtl/gray_code_counter.sv | 91 +++++++++
 tb/tb_gray_code_counter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/gray_code_counter_pkg.sv
// Shared types and helpers for the Gray code counter.
package gray_cnt_pkg;

   localparam int unsigned GRAY_CNT_WIDTH = 4;
   localparam int unsigned GRAY_CNT_MAX_WIDTH = 16;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Binary to reflected Gray code at the widest supported width.
   function automatic logic [GRAY_CNT_MAX_WIDTH-1:0] bin2gray(
      input logic [GRAY_CNT_MAX_WIDTH-1:0] bin
   );
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/gray_code_counter_if.sv
// Control and code-output bundle between the counter and its environment.
interface gray_code_counter_if #(
   parameter int unsigned WIDTH = gray_cnt_pkg::GRAY_CNT_WIDTH
);
   logic             en;
   logic             up_dn;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             out_ready;
   logic [WIDTH-1:0] gray_out;
   logic             gray_valid;
   logic             tc;
   logic             wrap;

   modport master (
      output en, up_dn, load, load_val, out_ready,
      input  gray_out, gray_valid, tc, wrap
   );

   modport slave (
      input  en, up_dn, load, load_val, out_ready,
      output gray_out, gray_valid, tc, wrap
   );
endinterface

// File: rtl/gray_code_counter_encoder.sv
// Combinational binary-to-Gray encoder feeding the gray_out register.
module binary_to_gray_encoder
   import gray_cnt_pkg::*;
#(
   parameter int unsigned WIDTH = GRAY_CNT_WIDTH
) (
   input  logic [WIDTH-1:0] bin_i,
   output logic [WIDTH-1:0] gray_o
);
   assign gray_o = WIDTH'(bin2gray(GRAY_CNT_MAX_WIDTH'(bin_i)));
endmodule

// File: rtl/gray_code_counter.sv
// Up/down binary counter presenting its value as a registered Gray code.
// Define GRAY_CNT_SATURATE_EN to saturate at the range ends instead of wrapping.
module gray_code_counter
   import gray_cnt_pkg::*;
#(
   parameter int unsigned WIDTH = GRAY_CNT_WIDTH
) (
   input logic                clk,
   input logic                rst,
   gray_code_counter_if.slave bus
);
   localparam logic [WIDTH-1:0] ALL_ONES = '1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [WIDTH-1:0] gray_q, gray_d;
   logic             wrap_q, wrap_d;
   logic             accept_c;
   logic             tc_c;
`ifdef GRAY_CNT_SATURATE_EN
   logic             sat_hit_q, sat_hit_d;
`endif

   // Terminal count doubles as the end-of-range test for the next step.
   assign tc_c     = bus.up_dn ? (bin_q == ALL_ONES) : (bin_q == '0);
   assign accept_c = bus.en && (bus.out_ready || (state_q == IDLE));

   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      wrap_d  = 1'b0;
`ifdef GRAY_CNT_SATURATE_EN
      sat_hit_d = sat_hit_q;
`endif
      if (bus.load) begin
         bin_d   = bus.load_val;
         state_d = RUN;
`ifdef GRAY_CNT_SATURATE_EN
         sat_hit_d = 1'b0;
`endif
      end else if (accept_c) begin
         if (state_q == IDLE) begin
            state_d = RUN;
         end else if (tc_c) begin
`ifdef GRAY_CNT_SATURATE_EN
            // Hold at the end; only the first blocked step reports.
            wrap_d    = !sat_hit_q;
            sat_hit_d = 1'b1;
`else
            wrap_d = 1'b1;
            bin_d  = bus.up_dn ? '0 : ALL_ONES;
`endif
         end else begin
            bin_d = bus.up_dn ? bin_q + WIDTH'(1) : bin_q - WIDTH'(1);
`ifdef GRAY_CNT_SATURATE_EN
            sat_hit_d = 1'b0;
`endif
         end
      end
   end

   binary_to_gray_encoder #(.WIDTH(WIDTH)) u_encoder (
      .bin_i  (bin_d),
      .gray_o (gray_d)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         bin_q   <= '0;
         gray_q  <= '0;
         wrap_q  <= 1'b0;
`ifdef GRAY_CNT_SATURATE_EN
         sat_hit_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         gray_q  <= gray_d;
         wrap_q  <= wrap_d;
`ifdef GRAY_CNT_SATURATE_EN
         sat_hit_q <= sat_hit_d;
`endif
      end
   end

   assign bus.gray_out   = gray_q;
   assign bus.gray_valid = (state_q == RUN);
   assign bus.wrap       = wrap_q;
   assign bus.tc         = tc_c;
endmodule

// File: tb/tb_gray_code_counter.sv
// Randomised and directed checks of gray_code_counter against an arithmetic reference model.
module tb_gray_code_counter;
   localparam int unsigned W = 4;
   localparam int MODV = 1 << W;
   localparam int MAXV = MODV - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gray_code_counter_if #(.WIDTH(W)) bus ();
   gray_code_counter #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference state: count value, output valid, expected wrap pulse.
   int m_cnt;
   bit m_valid, m_wrap, m_sathit, m_moved;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   function automatic int gray_of(input int b);
      return b ^ (b >> 1);
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_valid = 0; m_wrap = 0; m_sathit = 0; m_moved = 0;
   endtask

   task automatic model_step(input bit en, input bit up, input bit ld, input int lv, input bit rdy);
      bit at_end;
      bit wnext;
      wnext   = 0;
      m_moved = 0;
      if (ld) begin
         m_cnt = lv; m_valid = 1; m_sathit = 0;
      end else if (en && (rdy || !m_valid)) begin
         if (!m_valid) begin
            m_valid = 1;
         end else begin
            at_end = up ? (m_cnt == MAXV) : (m_cnt == 0);
`ifdef GRAY_CNT_SATURATE_EN
            if (at_end) begin
               wnext    = !m_sathit;
               m_sathit = 1;
            end else begin
               m_cnt    = up ? m_cnt + 1 : m_cnt - 1;
               m_sathit = 0;
               m_moved  = 1;
            end
`else
            wnext   = at_end;
            m_cnt   = (m_cnt + (up ? 1 : MODV - 1)) % MODV;
            m_moved = 1;
`endif
         end
      end
      m_wrap = wnext;
   endtask

   task automatic check_all(input string tag, input bit up);
      bit exp_tc;
      exp_tc = up ? (m_cnt == MAXV) : (m_cnt == 0);
      check_eq({tag, ":gray"},  32'(bus.gray_out),   32'(gray_of(m_cnt)));
      check_eq({tag, ":valid"}, 32'(bus.gray_valid), 32'(m_valid));
      check_eq({tag, ":wrap"},  32'(bus.wrap),       32'(m_wrap));
      check_eq({tag, ":tc"},    32'(bus.tc),         32'(exp_tc));
   endtask

   // One clock: drive inputs, advance, update model, compare.
   task automatic cyc(input bit en, input bit up, input bit ld, input int lv, input bit rdy,
                      input string tag);
      logic [W-1:0] prev;
      prev          = bus.gray_out;
      bus.en        = en;
      bus.up_dn     = up;
      bus.load      = ld;
      bus.load_val  = W'(lv);
      bus.out_ready = rdy;
      @(posedge clk);
      #1;
      model_step(en, up, ld, lv, rdy);
      check_all(tag, up);
      if (m_moved) check_eq({tag, ":1bit"}, 32'($countones(prev ^ bus.gray_out)), 32'd1);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic async_reset(input string tag);
      rst = 1'b0;
      #1;
      model_reset();
      check_all(tag, bus.up_dn);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      int exp33 [6];
      exp33 = '{0, 1, 3, 2, 6, 7};
      bus.en = 0; bus.up_dn = 1; bus.load = 0; bus.load_val = '0; bus.out_ready = 1;
      rst = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all("reset", 1'b1);
      rst = 1'b1;

      // Count up from reset: first edge presents code 0 as valid.
      for (int i = 0; i < 6; i++) begin
         cyc(1, 1, 0, 0, 1, "up6");
         check_eq("up6:seq", 32'(bus.gray_out), 32'(exp33[i]));
         check_eq("up6:vld", 32'(bus.gray_valid), 32'd1);
      end
      cyc(1, 1, 0, 0, 1, "to6");
      check_eq("to6:seq", 32'(bus.gray_out), 32'h5);

      // Mid-count asynchronous reset, then reload near the top.
      async_reset("midrst");
      check_eq("midrst:gray", 32'(bus.gray_out), 32'h0);
      check_eq("midrst:vld",  32'(bus.gray_valid), 32'h0);

      cyc(0, 1, 1, 15, 1, "ld15");
      check_eq("ld15:gray", 32'(bus.gray_out), 32'h8);
      check_eq("ld15:tc",   32'(bus.tc), 32'h1);
`ifdef GRAY_CNT_SATURATE_EN
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 0, 0, 1, "sat");
         check_eq("sat:gray", 32'(bus.gray_out), 32'h8);
         check_eq("sat:wrap", 32'(bus.wrap), (i == 0) ? 32'h1 : 32'h0);
         check_eq("sat:tc",   32'(bus.tc), 32'h1);
      end
      cyc(0, 1, 1, 0, 1, "ld0");
`else
      cyc(1, 1, 0, 0, 1, "upwrap");
      check_eq("upwrap:gray", 32'(bus.gray_out), 32'h0);
      check_eq("upwrap:wrap", 32'(bus.wrap), 32'h1);
      cyc(0, 1, 0, 0, 1, "upwrap2");
      check_eq("upwrap2:wrap", 32'(bus.wrap), 32'h0);
      cyc(1, 0, 0, 0, 1, "dnwrap");
      check_eq("dnwrap:gray", 32'(bus.gray_out), 32'h8);
      check_eq("dnwrap:wrap", 32'(bus.wrap), 32'h1);
      cyc(0, 0, 0, 0, 1, "dnwrap2");
      check_eq("dnwrap2:wrap", 32'(bus.wrap), 32'h0);
`endif

      // Stall with en high holds the code; load overrides the stall.
      cyc(0, 1, 1, 2, 1, "ld2");
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 0, 0, 0, "stall");
         check_eq("stall:gray", 32'(bus.gray_out), 32'h3);
      end
      cyc(1, 1, 1, 5, 0, "ldstall");
      check_eq("ldstall:gray", 32'(bus.gray_out), 32'h7);

      // Randomised traffic against the reference model.
      for (int i = 0; i < 600; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            async_reset("rnd_rst");
         end else begin
            cyc(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 99) < 6), int'($urandom_range(0, MAXV)),
                ($urandom_range(0, 9) < 7), "rnd");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
